// File: rtl/mux2_reg_pkg.sv
// Shared constants for the mux2_reg selector: select codes and default width.
package mux2_reg_pkg;

  localparam int DEF_WIDTH = 2;

  localparam logic [1:0] SEL_D0 = 2'd0;
  localparam logic [1:0] SEL_D1 = 2'd1;
  localparam logic [1:0] SEL_D2 = 2'd2;
  localparam logic [1:0] SEL_D3 = 2'd3;

endpackage : mux2_reg_pkg

// File: rtl/mux2_reg_mux4_comb.sv
// Pure combinational 4:1 word selector. An unknown select code yields all-zero.
module mux4_comb
  import mux2_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] d0_i,
  input  logic [WIDTH-1:0] d1_i,
  input  logic [WIDTH-1:0] d2_i,
  input  logic [WIDTH-1:0] d3_i,
  input  logic [1:0]       sel_i,
  output logic [WIDTH-1:0] y_o
);

  // Select one word; the default arm covers X/Z on sel and prevents a latch.
  always_comb begin
    y_o = '0;
    case (sel_i)
      SEL_D0:  y_o = d0_i;
      SEL_D1:  y_o = d1_i;
      SEL_D2:  y_o = d2_i;
      SEL_D3:  y_o = d3_i;
      default: y_o = '0;
    endcase
  end

endmodule : mux4_comb

// File: rtl/mux2_reg.sv
// 4:1 word selector with a combinational output Y and a clock-aligned copy
// y_q. y_vld rises on the first enabled capture after reset and stays high
// until the next reset; it is a sticky status flag, not a handshake, so there
// is no ready/back-pressure path.
module mux2_reg
  import mux2_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [WIDTH-1:0] D3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] y_q,
  output logic             y_vld
);

  logic [WIDTH-1:0] sel_word;
  logic [WIDTH-1:0] data_d, data_q;
  logic             vld_d, vld_q;

  mux4_comb #(.WIDTH(WIDTH)) u_mux (
    .d0_i  (D0),
    .d1_i  (D1),
    .d2_i  (D2),
    .d3_i  (D3),
    .sel_i (sel),
    .y_o   (sel_word)
  );

  assign Y = sel_word;

  // Next-state: capture the selected word when enabled, otherwise hold.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (en) begin
      data_d = sel_word;
      vld_d  = 1'b1;
    end
  end

  // Output register; reset clears both data and valid at once, independent of clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign y_q   = data_q;
  assign y_vld = vld_q;

endmodule : mux2_reg

// File: tb/tb_mux2_reg.sv
// Directed bench for mux2_reg: combinational select, capture/hold, async reset.
module tb_mux2_reg;

  localparam int W = 2;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [W-1:0] d0, d1, d2, d3;
  logic [1:0]   sel;
  logic [W-1:0] y, yq;
  logic         yv;

  int n_cmp;
  int n_bad;

  mux2_reg #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .D0    (d0),
    .D1    (d1),
    .D2    (d2),
    .D3    (d3),
    .sel   (sel),
    .Y     (y),
    .y_q   (yq),
    .y_vld (yv)
  );

  // One full clock period, edges made explicitly so the clock can sit idle.
  task automatic tick();
    #5 clk = 1'b1;
    #5 clk = 1'b0;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clk   = 1'b0;
    rst_n = 1'b0;
    en    = 1'b0;
    d0 = 2'b00; d1 = 2'b10; d2 = 2'b01; d3 = 2'b11;
    sel = 2'b00;
    #1;

    // Reset state
    check("rst_yq", yq, 2'b00);
    check("rst_vld", {1'b0, yv}, 2'b00);

    // Combinational select with clock idle
    sel = 2'b00; #10; check("y_sel00", y, 2'b00);
    sel = 2'b01; #10; check("y_sel01", y, 2'b10);
    sel = 2'b10; #10; check("y_sel10", y, 2'b01);
    sel = 2'b11; #10; check("y_sel11", y, 2'b11);

    // Data change propagates with no clock edge
    sel = 2'b01; #1;
    d1 = 2'b11; #0; #0;
    check("y_d1_same_step", y, 2'b11);
    #1; check("y_d1_follow", y, 2'b11);
    d1 = 2'b10; #1;

    // Release reset, capture one word
    rst_n = 1'b1; en = 1'b1; sel = 2'b11; d3 = 2'b11; #1;
    check("pre_edge_yq", yq, 2'b00);
    check("pre_edge_vld", {1'b0, yv}, 2'b00);
    tick();
    check("cap_yq", yq, 2'b11);
    check("cap_vld", {1'b0, yv}, 2'b01);

    // Hold with en=0 while Y moves
    en = 1'b0; sel = 2'b00;
    tick(); tick();
    check("hold_yq", yq, 2'b11);
    check("hold_y", y, 2'b00);
    check("hold_vld", {1'b0, yv}, 2'b01);
    en = 1'b1;
    tick();
    check("recap_yq", yq, 2'b00);

    // Capture 10 then assert reset between edges
    sel = 2'b01;
    tick();
    check("cap10_yq", yq, 2'b10);
    #2 rst_n = 1'b0; #1;
    check("async_rst_yq", yq, 2'b00);
    check("async_rst_vld", {1'b0, yv}, 2'b00);
    check("async_rst_y", y, 2'b10);

    // No capture while held in reset, even with en=1
    tick();
    check("in_rst_yq", yq, 2'b00);
    check("in_rst_vld", {1'b0, yv}, 2'b00);

    // Deassert between edges: still clear until the next edge
    rst_n = 1'b1; #1;
    check("deassert_yq", yq, 2'b00);
    tick();
    check("post_rst_yq", yq, 2'b10);
    check("post_rst_vld", {1'b0, yv}, 2'b01);

    // Different data pattern across all selects
    d0 = 2'b01; d1 = 2'b00; d2 = 2'b11; d3 = 2'b10;
    sel = 2'b00; #1; check("y2_sel00", y, 2'b01);
    sel = 2'b10; #1; check("y2_sel10", y, 2'b11);
    tick();
    check("cap2_yq", yq, 2'b11);
    sel = 2'b11; #1; check("y2_sel11", y, 2'b10);

    // Unknown select drives zero
    d0 = 2'b00;
    sel = 2'bxx; #1;
    check("y_selx", y, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_mux2_reg
